// File: rtl/shift_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//   Shared definitions for the multi-pass shift sequencer:
//     - DATA_W   : operand / result width (8)
//     - STEP_MAX : largest amount the shifter is asked to move in one pass (3)
//     - AMT_W    : width of the total shift/rotate amount (0..7)
//     - PASS_W   : width of the pass counter (0..3)
//     - SHAMT_W  : width of the shifter's amount input
//     - state_e  : sequencer FSM states
//     - pass_step: amount to apply in the next pass, min(remaining, STEP_MAX)
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam int DATA_W   = 8;
  localparam int STEP_MAX = 3;
  localparam int AMT_W    = 3;
  localparam int PASS_W   = 2;
  localparam int SHAMT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bits still to move are clamped to the per-pass limit.
  function automatic logic [PASS_W-1:0] pass_step(input logic [AMT_W-1:0] remaining);
    if (remaining > AMT_W'(STEP_MAX)) begin
      return PASS_W'(STEP_MAX);
    end
    return remaining[PASS_W-1:0];
  endfunction

endpackage

// File: rtl/shift_sequencer_shifter.sv
// -----------------------------------------------------------------------------
// shift_sequencer_shifter
//   Purely combinational 8-bit shifter / rotator.
//   Ports:
//     en_i   : enable; when 0 the operand passes through unchanged
//     s_i    : amount to move, 0..DATA_W-1
//     d_i    : direction, 0 = left, 1 = right
//     r_i    : mode, 0 = shift with fill, 1 = rotate
//     f_i    : fill bit for vacated positions in shift mode
//     data_i : operand
//     data_o : result
// -----------------------------------------------------------------------------
module shift_sequencer_shifter
  import shift_pkg::*;
(
  input  logic               en_i,
  input  logic [SHAMT_W-1:0] s_i,
  input  logic               d_i,
  input  logic               r_i,
  input  logic               f_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic [DATA_W-1:0]  data_o
);

  logic [DATA_W-1:0] rot_l;
  logic [DATA_W-1:0] rot_r;
  logic [DATA_W-1:0] shl;
  logic [DATA_W-1:0] shr;
  logic [DATA_W-1:0] fill_vec;

  // Rotations: the index arithmetic is SHAMT_W bits wide, so it wraps
  // modulo DATA_W for free.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rot
    assign rot_l[gi] = data_i[SHAMT_W'(gi) - s_i];
    assign rot_r[gi] = data_i[SHAMT_W'(gi) + s_i];
  end

  assign fill_vec = {DATA_W{f_i}};
  // Masks select exactly the vacated positions for each direction.
  assign shl = (data_i << s_i) | (fill_vec & ~({DATA_W{1'b1}} << s_i));
  assign shr = (data_i >> s_i) | (fill_vec & ~({DATA_W{1'b1}} >> s_i));

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case ({r_i, d_i})
        2'b00:   data_o = shl;
        2'b01:   data_o = shr;
        2'b10:   data_o = rot_l;
        default: data_o = rot_r;
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//   Accepts a shift/rotate command and applies it over several passes of an
//   8-bit combinational shifter, moving at most STEP_MAX bits per pass.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     in_valid / in_ready : command handshake (ready only while idle)
//     in_data    : operand
//     in_amt     : total amount 0..7
//     in_dir     : 0 = left, 1 = right
//     in_rot     : 0 = shift with fill, 1 = rotate
//     in_fill    : fill bit for shift mode
//     out_valid / out_ready : result handshake
//     out_data   : result
//     out_passes : number of shifter passes used
// -----------------------------------------------------------------------------
module shift_sequencer
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_dir,
  input  logic              in_rot,
  input  logic              in_fill,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PASS_W-1:0] out_passes
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [AMT_W-1:0]    rem_q, rem_d;
  logic [PASS_W-1:0]   passes_q, passes_d;
  logic                dir_q, dir_d;
  logic                rot_q, rot_d;
  logic                fill_q, fill_d;

  logic [PASS_W-1:0]   step;
  logic [DATA_W-1:0]   shift_out;

  assign step = pass_step(rem_q);

  // step is only consumed in SHIFT, where remaining is never zero.
  shift_sequencer_shifter u_shifter (
    .en_i   (1'b1),
    .s_i    ({{(SHAMT_W-PASS_W){1'b0}}, step}),
    .d_i    (dir_q),
    .r_i    (rot_q),
    .f_i    (fill_q),
    .data_i (work_q),
    .data_o (shift_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      rem_q    <= '0;
      passes_q <= '0;
      dir_q    <= 1'b0;
      rot_q    <= 1'b0;
      fill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      passes_q <= passes_d;
      dir_q    <= dir_d;
      rot_q    <= rot_d;
      fill_q   <= fill_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    rem_d    = rem_q;
    passes_d = passes_q;
    dir_d    = dir_q;
    rot_d    = rot_q;
    fill_d   = fill_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d   = in_data;
          rem_d    = in_amt;
          passes_d = '0;
          dir_d    = in_dir;
          rot_d    = in_rot;
          fill_d   = in_fill;
          state_d  = (in_amt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d   = shift_out;
        rem_d    = rem_q - AMT_W'(step);
        passes_d = passes_q + PASS_W'(1);
        if (rem_d == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // No bypass: a waiting command is taken only once back in IDLE.
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_data   = work_q;
  assign out_passes = passes_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic       in_dir;
  logic       in_rot;
  logic       in_fill;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_passes;

  int tests = 0;
  int fails = 0;

  shift_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_dir     (in_dir),
    .in_rot     (in_rot),
    .in_fill    (in_fill),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_passes (out_passes)
  );

  always #5 clk = ~clk;

  // Reference: a single shift/rotate by the full amount, bit by bit.
  function automatic logic [7:0] ref_result(input logic [7:0] d, input int amt,
                                            input logic dir, input logic rot,
                                            input logic fill);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      if (rot) begin
        if (dir) r[i] = d[(i + amt) % 8];
        else     r[i] = d[(i + 8 - amt) % 8];
      end else begin
        if (dir) r[i] = (i + amt < 8) ? d[i + amt] : fill;
        else     r[i] = (i >= amt) ? d[i - amt] : fill;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the command just accepted; counts edges to out_valid.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 8) begin
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic scramble_inputs();
    in_data = 8'($urandom);
    in_amt  = 3'($urandom);
    in_dir  = 1'($urandom);
    in_rot  = 1'($urandom);
    in_fill = 1'($urandom);
  endtask

  task automatic do_cmd(input logic [7:0] d, input int amt, input logic dir,
                        input logic rot, input logic fill, input int hold);
    logic [7:0] exp_d;
    int exp_p;
    int lat;
    exp_d = ref_result(d, amt, dir, rot, fill);
    exp_p = (amt + 2) / 3;
    chk("ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_amt = 3'(amt);
    in_dir = dir; in_rot = rot; in_fill = fill; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
    wait_result(lat);
    chk("latency", 32'(lat), 32'(exp_p));
    chk("out_data", 32'(out_data), 32'(exp_d));
    chk("out_passes", 32'(out_passes), 32'(exp_p));
    for (int h = 0; h < hold; h++) begin
      scramble_inputs();
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(exp_d));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("after_hs_valid", 32'(out_valid), 32'd0);
    chk("after_hs_ready", 32'(in_ready), 32'd1);
    $display("[TB] cmd d=%02h amt=%0d dir=%0d rot=%0d fill=%0d -> %02h passes=%0d lat=%0d",
             d, amt, dir, rot, fill, out_data, exp_p, lat);
  endtask

  initial begin
    logic [7:0] held;
    logic [7:0] exp2;
    int lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 8'h00; in_amt = 3'd0; in_dir = 1'b0; in_rot = 1'b0; in_fill = 1'b0;

    // Reset state before any clock edge.
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_out_passes", 32'(out_passes), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    do_cmd(8'hA5, 0, 1'b0, 1'b0, 1'b0, 0);
    do_cmd(8'h81, 5, 1'b0, 1'b0, 1'b1, 1);
    do_cmd(8'h01, 7, 1'b1, 1'b1, 1'b0, 0);
    do_cmd(8'hF0, 3, 1'b1, 1'b0, 1'b0, 0);
    chk("vec_35_data", 32'(out_data), 32'h1E);

    // Backpressure with a second command waiting.
    in_valid = 1'b1; in_data = 8'h3C; in_amt = 3'd4; in_dir = 1'b0;
    in_rot = 1'b1; in_fill = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 8'hC3; in_amt = 3'd2; in_dir = 1'b1; in_rot = 1'b0; in_fill = 1'b1;
    wait_result(lat);
    chk("bp_latency", 32'(lat), 32'd2);
    held = out_data;
    chk("bp_data", 32'(held), 32'(ref_result(8'h3C, 4, 1'b0, 1'b1, 1'b0)));
    for (int h = 0; h < 4; h++) begin
      @(posedge clk); #1;
      chk("bp_stable", 32'(out_data), 32'(held));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_no_bypass", 32'(in_ready), 32'd1);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_accept", 32'(in_ready), 32'd0);
    exp2 = ref_result(8'hC3, 2, 1'b1, 1'b0, 1'b1);
    wait_result(lat);
    chk("bp2_latency", 32'(lat), 32'd1);
    chk("bp2_data", 32'(out_data), 32'(exp2));
    chk("bp2_passes", 32'(out_passes), 32'd1);
    $display("[TB] backpressure second cmd -> %02h", out_data);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during the second pass of an amt-7 command.
    in_valid = 1'b1; in_data = 8'h5A; in_amt = 3'd7; in_dir = 1'b0;
    in_rot = 1'b1; in_fill = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_passes", 32'(out_passes), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'h00);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("post_rst_no_result", 32'(out_valid), 32'd0);
    end
    $display("[TB] mid-operation reset done");

    // Randomized commands against the reference model.
    for (int n = 0; n < 40; n++) begin
      do_cmd(8'($urandom), int'($urandom_range(7, 0)), 1'($urandom),
             1'($urandom), 1'($urandom), int'($urandom_range(3, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameters: none; data width SHALL be fixed at 8 bits and per-pass step limit at 3, both taken from the shared package.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  command present.
REQ-005 in_ready  output  1  sequencer can accept a command.
REQ-006 in_data  input  8  operand.
REQ-007 in_amt  input  3  total shift/rotate amount, 0..7.
REQ-008 in_dir  input  1  direction: 0 = left, 1 = right.
REQ-009 in_rot  input  1  mode: 0 = shift with fill, 1 = rotate.
REQ-010 in_fill  input  1  fill bit for shift mode.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_data  output  8  result.
REQ-014 out_passes  output  2  number of shifter passes used, 0..3.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE and SHALL be decoded combinationally from state.
REQ-017 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1.
- Latch in_data into the work register and in_amt into remaining.
- Latch in_dir, in_rot and in_fill.
- Clear the pass counter.
REQ-018 On accept, the next state SHALL be DONE if in_amt=0, otherwise SHIFT.
REQ-019 Each SHIFT cycle SHALL perform one pass.
- step = min(remaining, 3).
- work <= the 8-bit shifter result for (work, step, latched dir/rot/fill).
- remaining <= remaining - step.
- passes <= passes + 1.
REQ-020 In SHIFT, if remaining - step = 0 the next state SHALL be DONE; otherwise the FSM SHALL stay in SHIFT.
REQ-021 out_valid SHALL rise exactly ceil(in_amt/3) edges after the accept edge.
- amt 0: in the cycle immediately after accept.
- amt 7: after 3 passes (3, 3, 1).
REQ-022 Pass semantics:
- Shift mode: vacated bits take the fill value.
- Rotate mode: wrap-around is modulo 8.
- Composed passes SHALL equal a single shift or rotate by in_amt.
REQ-023 In DONE, out_valid SHALL be 1, and out_data (=work) and out_passes SHALL be held stable until out_ready=1.
REQ-024 On an edge with out_valid=1 and out_ready=1, the next state SHALL be IDLE; there is no same-cycle accept of a new command (no bypass).
REQ-025 Changes on in_* while not in IDLE SHALL be ignored.
REQ-026 out_valid SHALL be 0 in IDLE and SHIFT.

Reset
REQ-027 While rst_n=0, regardless of clk:
- state = IDLE, work = 0x00, remaining = 0, passes = 0, latched controls = 0.
- out_valid = 0, out_data = 0x00, out_passes = 0, in_ready = 1.
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no result SHALL be presented after reset releases.

Structure
REQ-029 Package shift_pkg SHALL hold:
- the FSM state enum;
- DATA_W = 8;
- STEP_MAX = 3.
REQ-030 The block SHALL instantiate the existing combinational 8-bit shifter as its single sub-module.
- En tied 1.
- S driven by step (step 0 is never issued).
- D, R and F driven from the latched controls.
REQ-031 All registers SHALL reside in shift_sequencer; the shifter SHALL remain purely combinational.

Verification
REQ-032 data 0xA5, amt 0 -> out_data 0xA5, out_passes 0, out_valid 1 the cycle after accept.
REQ-033 data 0x81, left, shift, fill 1, amt 5 -> out_data 0x3F, out_passes 2, out_valid 2 edges after accept.
REQ-034 data 0x01, right, rotate, amt 7 -> out_data 0x02, out_passes 3.
REQ-035 data 0xF0, right, shift, fill 0, amt 3 -> out_data 0x1E, out_passes 1.
REQ-036 Backpressure: hold out_ready=0 for 4 cycles with a second command on in_valid.
- out_data stays stable and in_ready stays 0.
- The second command is accepted only on the first edge after the out handshake.
REQ-037 Reset mid-operation: drop rst_n during the second pass of an amt-7 command.
- out_valid = 0 and in_ready = 1 immediately (asynchronous).
- No result appears after release.
